// File: rtl/dsp_simd_pkg.sv
// Shared definitions for the three-lane 12-bit SIMD DSP primitives and their packer.
package dsp_simd_pkg;

  localparam int LANES  = 3;
  localparam int LANE_W = 12;

  typedef enum logic {FILL, HOLD} pack_state_t;

  // Lane-valid mask for a bundle whose last filled lane index is `count`.
  function automatic logic [LANES-1:0] lane_mask(input logic [1:0] count);
    case (count)
      2'd0:    lane_mask = 3'b001;
      2'd1:    lane_mask = 3'b011;
      default: lane_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/dsp_lane_packer_v3.sv
// Gathers up to three scalar operand pairs into one registered SIMD bundle,
// with a fill buffer that can hold a finished bundle while the consumer stalls.
module dsp_lane_packer_v3
  import dsp_simd_pkg::*;
#(
  parameter int width = 12
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_a,
  input  logic [width-1:0] in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] a0,
  output logic [width-1:0] a1,
  output logic [width-1:0] a2,
  output logic [width-1:0] b0,
  output logic [width-1:0] b1,
  output logic [width-1:0] b2,
  output logic [2:0]       out_mask
);

  generate
    if (width < 1 || width > LANE_W) begin : g_bad_width
      $error("dsp_lane_packer_v3: width must be in 1..12");
    end
  endgenerate

  pack_state_t      state_p0;
  logic [1:0]       count_p0;
  logic [LANES-1:0] hold_mask_p0;
  logic [width-1:0] slot_a_p0 [LANES];
  logic [width-1:0] slot_b_p0 [LANES];

  logic             fire;
  logic             completing;
  logic             out_free;
  logic             load_fill;
  logic             load_hold;
  logic [LANES-1:0] src_mask;
  logic [width-1:0] nxt_a [LANES];
  logic [width-1:0] nxt_b [LANES];

  assign in_ready   = (state_p0 == FILL);
  assign fire       = in_valid && in_ready;
  assign completing = (count_p0 == 2'd2) || in_last;
  assign out_free   = !out_valid || out_ready;
  assign load_fill  = fire && completing && out_free;
  assign load_hold  = (state_p0 == HOLD) && out_free;

  // Bundle assembly: in FILL the incoming pair occupies lane `count`; lanes
  // outside the mask are forced to zero so stale slot data never leaks out.
  always_comb begin
    src_mask = (state_p0 == HOLD) ? hold_mask_p0 : lane_mask(count_p0);
    for (int i = 0; i < LANES; i++) begin
      nxt_a[i] = '0;
      nxt_b[i] = '0;
      if (src_mask[i]) begin
        if (state_p0 == FILL && count_p0 == 2'(i)) begin
          nxt_a[i] = in_a;
          nxt_b[i] = in_b;
        end else begin
          nxt_a[i] = slot_a_p0[i];
          nxt_b[i] = slot_b_p0[i];
        end
      end
    end
  end

  // Fill buffer and output register set
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_p0     <= FILL;
      count_p0     <= 2'd0;
      hold_mask_p0 <= '0;
      for (int i = 0; i < LANES; i++) begin
        slot_a_p0[i] <= '0;
        slot_b_p0[i] <= '0;
      end
      out_valid <= 1'b0;
      out_mask  <= '0;
      a0 <= '0; a1 <= '0; a2 <= '0;
      b0 <= '0; b1 <= '0; b2 <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;

      if (fire) begin
        slot_a_p0[count_p0] <= in_a;
        slot_b_p0[count_p0] <= in_b;
        if (!completing) begin
          count_p0 <= count_p0 + 2'd1;
        end else if (!out_free) begin
          hold_mask_p0 <= lane_mask(count_p0);
          state_p0     <= HOLD;
        end else begin
          count_p0 <= 2'd0;
        end
      end

      if (load_hold) begin
        state_p0 <= FILL;
        count_p0 <= 2'd0;
      end

      if (load_fill || load_hold) begin
        out_valid <= 1'b1;
        out_mask  <= src_mask;
        a0 <= nxt_a[0]; a1 <= nxt_a[1]; a2 <= nxt_a[2];
        b0 <= nxt_b[0]; b1 <= nxt_b[1]; b2 <= nxt_b[2];
      end
    end
  end

endmodule

// File: tb/tb_dsp_lane_packer_v3.sv
// Scoreboard bench for dsp_lane_packer_v3: directed beats push expected bundles,
// a monitor pops and compares every delivered bundle.
module tb_dsp_lane_packer_v3;

  typedef struct packed {
    logic [11:0] a0, a1, a2, b0, b1, b2;
    logic [2:0]  mask;
  } bundle_t;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [11:0] in_a = '0, in_b = '0;
  logic        in_ready, out_valid;
  logic [11:0] a0, a1, a2, b0, b1, b2;
  logic [2:0]  out_mask;

  logic        v4 = 1'b0, l4 = 1'b0;
  logic [3:0]  ia4 = '0, ib4 = '0;
  logic        r4, ov4;
  logic [3:0]  x0, x1, x2, y0, y1, y2;
  logic [2:0]  m4;

  int checks = 0;
  int failures = 0;
  bundle_t exp_q[$];
  bundle_t prev;
  logic    prev_stall = 1'b0;

  dsp_lane_packer_v3 #(.width(12)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .a0(a0), .a1(a1), .a2(a2), .b0(b0), .b1(b1), .b2(b2),
    .out_mask(out_mask)
  );

  dsp_lane_packer_v3 #(.width(4)) dut4 (
    .clock(clock), .reset(reset), .in_valid(v4), .in_ready(r4),
    .in_a(ia4), .in_b(ib4), .in_last(l4), .out_valid(ov4),
    .out_ready(1'b1), .a0(x0), .a1(x1), .a2(x2), .b0(y0), .b1(y1), .b2(y2),
    .out_mask(m4)
  );

  always #5 clock = ~clock;

  function automatic bundle_t cur();
    bundle_t c;
    c = '{a0: a0, a1: a1, a2: a2, b0: b0, b1: b1, b2: b2, mask: out_mask};
    return c;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every output transfer pops one expected bundle; stalled bundles must hold.
  always @(negedge clock) begin
    if (reset) begin
      if (prev_stall && out_valid) check("held_stable", 128'(cur()), 128'(prev));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_bundle", 128'(cur()), 128'(0));
        else check("bundle", 128'(cur()), 128'(exp_q.pop_front()));
      end
      prev_stall = out_valid && !out_ready;
      prev = cur();
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send(input logic [11:0] a, input logic [11:0] b, input logic last);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_a = a; in_b = b; in_last = last;
    for (int n = 0; n < 50; n++) begin
      @(negedge clock);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("send_timeout", 128'(0), 128'(1));
    @(posedge clock); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic push(input bundle_t b);
    exp_q.push_back(b);
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 30 && exp_q.size() != 0; n++) @(posedge clock);
    @(negedge clock);
    check(name, 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    // Reset state
    #12;
    check("reset_outputs", 128'({out_valid, out_mask, a0, a1, a2, b0, b1, b2}), 128'(0));
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
    check("ready_after_reset", 128'(in_ready), 128'(1));

    // Full rate, two bundles, in_ready high throughout
    @(posedge clock); #1;
    push('{a0: 1, a1: 2, a2: 3, b0: 'h10, b1: 'h11, b2: 'h12, mask: 3'b111});
    push('{a0: 4, a1: 5, a2: 6, b0: 'h13, b1: 'h14, b2: 'h15, mask: 3'b111});
    for (int i = 0; i < 6; i++) begin
      check("full_rate_ready", 128'(in_ready), 128'(1));
      send(12'(i + 1), 12'('h10 + i), 1'b0);
    end
    drain("full_rate_drain");

    // Partial flush
    @(posedge clock); #1;
    push('{a0: 7, a1: 8, a2: 0, b0: 'h20, b1: 'h21, b2: 0, mask: 3'b011});
    send(12'd7, 12'h20, 1'b0);
    send(12'd8, 12'h21, 1'b1);
    check("flush_latency", 128'(out_valid), 128'(1));
    drain("flush_drain");

    // Backpressure
    @(posedge clock); #1;
    out_ready = 1'b0;
    push('{a0: 'h31, a1: 'h32, a2: 'h33, b0: 'h41, b1: 'h42, b2: 'h43, mask: 3'b111});
    push('{a0: 'h34, a1: 'h35, a2: 'h36, b0: 'h44, b1: 'h45, b2: 'h46, mask: 3'b111});
    for (int i = 0; i < 6; i++) send(12'('h31 + i), 12'('h41 + i), 1'b0);
    @(negedge clock);
    check("hold_ready_low", 128'(in_ready), 128'(0));
    check("hold_first_bundle", 128'(cur()), 128'(exp_q[0]));
    repeat (3) @(posedge clock);
    #1 out_ready = 1'b1;
    drain("backpressure_drain");
    check("ready_after_hold", 128'(in_ready), 128'(1));

    // Single lane
    @(posedge clock); #1;
    push('{a0: 'hABC, a1: 0, a2: 0, b0: 'h123, b1: 0, b2: 0, mask: 3'b001});
    send(12'hABC, 12'h123, 1'b1);
    drain("single_drain");

    // Reset mid-bundle
    @(posedge clock); #1;
    send(12'h55, 12'h66, 1'b0);
    send(12'h57, 12'h68, 1'b0);
    @(negedge clock); #2 reset = 1'b0;
    #2 check("mid_reset_outputs", 128'({out_valid, out_mask, a0, a1, a2, b0, b1, b2}), 128'(0));
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    push('{a0: 9, a1: 10, a2: 11, b0: 'h19, b1: 'h1A, b2: 'h1B, mask: 3'b111});
    for (int i = 0; i < 3; i++) send(12'(9 + i), 12'('h19 + i), 1'b0);
    drain("reset_drain");
    repeat (4) @(posedge clock);

    // width = 4 instance
    @(posedge clock); #1;
    v4 = 1'b1; ia4 = 4'hF; ib4 = 4'h0; @(posedge clock); #1;
    ia4 = 4'h8; ib4 = 4'h7; @(posedge clock); #1;
    ia4 = 4'h1; ib4 = 4'hE; @(posedge clock); #1;
    v4 = 1'b0;
    @(negedge clock);
    check("w4_valid", 128'(ov4), 128'(1));
    check("w4_a", 128'({x0, x1, x2}), 128'(12'hF81));
    check("w4_b", 128'({y0, y1, y2, m4}), 128'({12'h07E, 3'b111}));

    repeat (3) @(posedge clock);
    check("queue_empty_end", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
